// File: rtl/subleq_pkg.sv
// Shared widths, reset PC and controller state encoding for the SUBLEQ core.
package subleq_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    typedef enum logic [2:0] {
        FETCH_A = 3'd0,
        FETCH_B = 3'd1,
        FETCH_C = 3'd2,
        READ_A  = 3'd3,
        READ_B  = 3'd4,
        WRITE   = 3'd5,
        HALT    = 3'd6
    } state_t;

endpackage

// File: rtl/subleq.sv
// SUBLEQ core: six single-port memory accesses per instruction, mem[B] -= mem[A],
// branch to C when the wrapped result is <= 0; a negative taken target halts.
module subleq
    import subleq_pkg::*;
(
    output logic [ADDR_W-1:0] addr,
    output logic              writeEnable,
    output logic [DATA_W-1:0] writeData,
    input  logic [DATA_W-1:0] readData,
    input  logic              clk,
    input  logic              reset
);

    state_t                    state;
    state_t                    state_next;
    logic        [ADDR_W-1:0]  pc;
    logic        [ADDR_W-1:0]  pc_next;
    logic        [ADDR_W-1:0]  field_a;
    logic        [ADDR_W-1:0]  field_b;
    logic        [DATA_W-1:0]  field_c;
    logic signed [DATA_W-1:0]  op_a;
    logic signed [DATA_W-1:0]  diff;

    function automatic logic signed [DATA_W-1:0] sub_wrap(
        input logic signed [DATA_W-1:0] b,
        input logic signed [DATA_W-1:0] a
    );
        return b - a;
    endfunction

    function automatic logic le_zero(input logic signed [DATA_W-1:0] v);
        return (v < 0) || (v == '0);
    endfunction

    always_comb begin
        state_next = state;
        pc_next    = pc;
        case (state)
            FETCH_A: state_next = FETCH_B;
            FETCH_B: state_next = FETCH_C;
            FETCH_C: state_next = READ_A;
            READ_A:  state_next = READ_B;
            READ_B:  state_next = WRITE;
            WRITE: begin
                if (le_zero(diff)) begin
                    // A negative branch target is the halt request; PC is frozen.
                    if (field_c[DATA_W-1]) begin
                        state_next = HALT;
                    end else begin
                        state_next = FETCH_A;
                        pc_next    = field_c[ADDR_W-1:0];
                    end
                end else begin
                    state_next = FETCH_A;
                    pc_next    = pc + ADDR_W'(3);
                end
            end
            HALT:    state_next = HALT;
            default: state_next = FETCH_A;
        endcase
    end

    always_comb begin
        addr        = '0;
        writeEnable = 1'b0;
        writeData   = '0;
        if (!reset) begin
            case (state)
                FETCH_A: addr = pc;
                FETCH_B: addr = pc + ADDR_W'(1);
                FETCH_C: addr = pc + ADDR_W'(2);
                READ_A:  addr = field_a;
                READ_B:  addr = field_b;
                WRITE: begin
                    addr        = field_b;
                    writeEnable = 1'b1;
                    writeData   = diff;
                end
                HALT:    addr = pc;
                default: addr = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH_A;
            pc      <= RESET_PC;
            field_a <= '0;
            field_b <= '0;
            field_c <= '0;
            op_a    <= '0;
            diff    <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            case (state)
                FETCH_A: field_a <= readData[ADDR_W-1:0];
                FETCH_B: field_b <= readData[ADDR_W-1:0];
                FETCH_C: field_c <= readData;
                READ_A:  op_a    <= readData;
                READ_B:  diff    <= sub_wrap(readData, op_a);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_subleq.sv
// Bench for the SUBLEQ core with a behavioural 1024x32 memory (combinational read, synchronous write).
module tb_subleq;
    logic [9:0]  addr;
    logic        writeEnable;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic [31:0] mem [1024];
    logic        ld_en = 1'b0;
    logic [9:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] a_val;
        logic [31:0] b_val;
        logic [31:0] exp_wd;
        logic [9:0]  exp_next;
    } vec_t;

    vec_t vecs [6];

    subleq dut (
        .addr(addr),
        .writeEnable(writeEnable),
        .writeData(writeData),
        .readData(readData),
        .clk(clk),
        .reset(reset)
    );

    always #5 clk = ~clk;

    assign readData = mem[addr];

    always @(posedge clk) begin
        if (ld_en)
            mem[ld_addr] <= ld_data;
        else if (writeEnable)
            mem[addr] <= writeData;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Positioned at posedge+1: check outputs at the following negedge, then advance one cycle.
    task automatic step(input string name, input logic [9:0] ea, input logic ewe, input logic [31:0] ewd);
        @(negedge clk);
        chk({name, ".addr"}, 32'(addr), 32'(ea));
        chk({name, ".we"}, 32'(writeEnable), 32'(ewe));
        chk({name, ".wd"}, writeData, ewd);
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [9:0] a, input logic [31:0] d);
        ld_en = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    task automatic enter_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic leave_reset();
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"fall",     32'd5,          32'd7,          32'd2,          10'd3};
        vecs[1] = '{"zero",     32'd5,          32'd5,          32'd0,          10'd6};
        vecs[2] = '{"neg",      32'd9,          32'd4,          32'hFFFFFFFB,   10'd6};
        vecs[3] = '{"ovf",      32'd1,          32'h80000000,   32'h7FFFFFFF,   10'd3};
        vecs[4] = '{"minint",   32'h80000000,   32'd0,          32'h80000000,   10'd6};
        vecs[5] = '{"wrapneg",  32'hFFFFFFFF,   32'h7FFFFFFF,   32'h80000000,   10'd6};

        for (int i = 0; i < 1024; i++) mem[i] = '0;

        // Reset-state outputs
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst.addr", 32'(addr), 32'd0);
        chk("rst.we", 32'(writeEnable), 32'd0);
        chk("rst.wd", writeData, 32'd0);

        // Single-instruction vectors at PC 0: A=10, B=11, C=6
        for (int i = 0; i < 6; i++) begin
            enter_reset();
            load(10'd0, 32'd10);
            load(10'd1, 32'd11);
            load(10'd2, 32'd6);
            load(10'd10, vecs[i].a_val);
            load(10'd11, vecs[i].b_val);
            leave_reset();
            step({vecs[i].name, ".c1"}, 10'd0, 1'b0, 32'd0);
            step({vecs[i].name, ".c2"}, 10'd1, 1'b0, 32'd0);
            step({vecs[i].name, ".c3"}, 10'd2, 1'b0, 32'd0);
            step({vecs[i].name, ".c4"}, 10'd10, 1'b0, 32'd0);
            step({vecs[i].name, ".c5"}, 10'd11, 1'b0, 32'd0);
            step({vecs[i].name, ".c6"}, 10'd11, 1'b1, vecs[i].exp_wd);
            step({vecs[i].name, ".next"}, vecs[i].exp_next, 1'b0, 32'd0);
            chk({vecs[i].name, ".mem11"}, mem[11], vecs[i].exp_wd);
        end

        // Halt: A=B=12, C negative
        enter_reset();
        load(10'd0, 32'd12);
        load(10'd1, 32'd12);
        load(10'd2, 32'hFFFFFFFF);
        load(10'd12, 32'd77);
        leave_reset();
        step("halt.c1", 10'd0, 1'b0, 32'd0);
        step("halt.c2", 10'd1, 1'b0, 32'd0);
        step("halt.c3", 10'd2, 1'b0, 32'd0);
        step("halt.c4", 10'd12, 1'b0, 32'd0);
        step("halt.c5", 10'd12, 1'b0, 32'd0);
        step("halt.c6", 10'd12, 1'b1, 32'd0);
        chk("halt.mem12", mem[12], 32'd0);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            chk("halt.we", 32'(writeEnable), 32'd0);
            chk("halt.addr", 32'(addr), 32'd0);
        end

        // Reset asserted during WRITE suppresses the store
        enter_reset();
        load(10'd0, 32'd10);
        load(10'd1, 32'd11);
        load(10'd2, 32'd6);
        load(10'd10, 32'd5);
        load(10'd11, 32'd7);
        leave_reset();
        step("rw.c1", 10'd0, 1'b0, 32'd0);
        step("rw.c2", 10'd1, 1'b0, 32'd0);
        step("rw.c3", 10'd2, 1'b0, 32'd0);
        step("rw.c4", 10'd10, 1'b0, 32'd0);
        step("rw.c5", 10'd11, 1'b0, 32'd0);
        reset = 1'b1;
        step("rw.c6", 10'd0, 1'b0, 32'd0);
        reset = 1'b0;
        chk("rw.mem11", mem[11], 32'd7);
        step("rw.f1", 10'd0, 1'b0, 32'd0);
        step("rw.f2", 10'd1, 1'b0, 32'd0);
        step("rw.f3", 10'd2, 1'b0, 32'd0);

        // PC wrap: jump to 1021, fall through to 0; operand upper bits ignored
        enter_reset();
        load(10'd0, 32'd20);
        load(10'd1, 32'd20);
        load(10'd2, 32'd1021);
        load(10'd20, 32'd3);
        load(10'd1021, 32'hABCDF40A);
        load(10'd1022, 32'h0000040B);
        load(10'd1023, 32'd6);
        load(10'd10, 32'd5);
        load(10'd11, 32'd7);
        leave_reset();
        step("pw.c1", 10'd0, 1'b0, 32'd0);
        step("pw.c2", 10'd1, 1'b0, 32'd0);
        step("pw.c3", 10'd2, 1'b0, 32'd0);
        step("pw.c4", 10'd20, 1'b0, 32'd0);
        step("pw.c5", 10'd20, 1'b0, 32'd0);
        step("pw.c6", 10'd20, 1'b1, 32'd0);
        step("pw.c7", 10'd1021, 1'b0, 32'd0);
        step("pw.c8", 10'd1022, 1'b0, 32'd0);
        step("pw.c9", 10'd1023, 1'b0, 32'd0);
        step("pw.c10", 10'd10, 1'b0, 32'd0);
        step("pw.c11", 10'd11, 1'b0, 32'd0);
        step("pw.c12", 10'd11, 1'b1, 32'd2);
        step("pw.c13", 10'd0, 1'b0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/subleq.md
# subleq

Single-instruction (SUBLEQ) processor core using one shared 1024×32 word memory through a single port. Each instruction is three consecutive words A, B, C. The core computes mem[B] ← mem[B] − mem[A], then branches to C if the result ≤ 0, otherwise falls through to PC+3. It sits beside an external memory that has combinational read and synchronous write.

## Interface
- No parameters. Fixed: address width 10 bits, data width 32 bits, reset PC 0.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high. Sampled only on the rising edge of clk.
- addr  out  10  memory word address for the current cycle's read and write.
- writeEnable  out  1  when high, memory stores writeData at addr on the next rising clk edge.
- writeData  out  32  data to store.
- readData  in  32  memory word at addr; combinational, same cycle.
- Positional port order is fixed: addr, writeEnable, writeData, readData, clk, reset.

## Operation
- Registers:
  - PC[9:0]
  - fieldA[9:0], fieldB[9:0]
  - fieldC[31:0]: full word, kept for the halt test.
  - opA[31:0], diff[31:0]
  - state
- States and actions. "Latch" means capture readData at the clock edge.
  - FETCH_A: addr=PC; latch fieldA=readData[9:0].
  - FETCH_B: addr=PC+1; latch fieldB=readData[9:0].
  - FETCH_C: addr=PC+2; latch fieldC=readData.
  - READ_A: addr=fieldA; latch opA=readData.
  - READ_B: addr=fieldB; latch diff=readData−opA.
  - WRITE: addr=fieldB, writeData=diff, writeEnable=1. Next PC = fieldC[9:0] if diff ≤ 0 (signed), else PC+3. Next state FETCH_A, or HALT (see below).
  - HALT: addr=PC, writeEnable=0. Stays here until reset.
- State order is FETCH_A → FETCH_B → FETCH_C → READ_A → READ_B → WRITE.
- Halt rule: if the branch is taken and fieldC[31]=1 (negative target), go to HALT and leave PC unchanged.
- Arithmetic:
  - 32-bit two's-complement subtraction, wrap on overflow, no saturation.
  - The ≤ 0 test is on the wrapped 32-bit result: bit31 set, or all bits zero.
- Address arithmetic: PC+1, PC+2 and PC+3 wrap modulo 1024. Operand fields A and B use only bits [9:0]; upper bits are ignored.
- A=B is legal: the result is 0, so the write stores 0 and the branch is taken.
- Reads and writes never overlap except the WRITE cycle, which writes fieldB only.
- Self-modifying code is legal. Fetches always read the current memory contents.

## Timing
- Exactly 6 cycles per instruction: one memory access per cycle, write in the 6th.
- Reset values: state=FETCH_A, PC=0, all other registers 0.
  - Outputs during reset: addr=0, writeEnable=0, writeData=0.
- First fetch: addr=0 in the first cycle after reset deasserts. First write is in the 6th cycle after reset deasserts.
- writeEnable = (state==WRITE) && !reset. Asserting reset in a WRITE cycle suppresses that write.
- Reset asserted in any state returns to FETCH_A with PC=0 on the next edge.
- addr, writeEnable and writeData are combinational decodes of state and registers only. No readData→output combinational path.
- writeData = diff in WRITE, 0 otherwise.

## Structure
- Shared package subleq_pkg holds:
  - ADDR_W=10, DATA_W=32, RESET_PC=0
  - the state enum: FETCH_A, FETCH_B, FETCH_C, READ_A, READ_B, WRITE, HALT.
- No sub-modules. A single FSM with its datapath is natural.
- The memory stays external.

## Test plan
- Fall-through: mem[0..2]=10,11,6; mem[10]=5; mem[11]=7.
  - Cycle 6: writeEnable=1, addr=11, writeData=2.
  - Next fetch addr=3.
- Branch on zero: same program with mem[11]=5 → mem[11]=0, next fetch addr=6.
- Branch on negative: mem[10]=9, mem[11]=4 → writeData=0xFFFFFFFB, next fetch addr=6.
- Halt: mem[0..2]=12,12,0xFFFFFFFF.
  - mem[12] becomes 0.
  - After that: writeEnable stays 0 and addr stays 0 for 100 cycles.
- Overflow wrap: mem[A]=1, mem[B]=0x80000000 → writeData=0x7FFFFFFF, no branch.
- Reset during WRITE: no memory write occurs; next cycle addr=0 and state FETCH_A.
- PC wrap: instruction at 1021 falls through → fetches 1021, 1022, 1023, then addr=0.
